// File: rtl/alu_control_mdu_if.sv
// EX-stage bundle between the pipeline (master) and alu_control_mdu (slave).
interface alu_control_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_in;
    logic            flush;
    logic [2:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_control_out;
    logic            md_sel;
    logic [XLEN-1:0] md_result;
    logic            md_done;
    logic            stall;

    modport master (
        output valid_in, flush, alu_op, funct3, funct7, op_a, op_b,
        input  alu_control_out, md_sel, md_result, md_done, stall
    );

    modport slave (
        input  valid_in, flush, alu_op, funct3, funct7, op_a, op_b,
        output alu_control_out, md_sel, md_result, md_done, stall
    );
endinterface

// File: rtl/alu_control_mdu.sv
// EX-stage ALU decoder plus iterative RV32M multiply/divide sequencer with stall handshake.
// Define FAST_MUL_EN to make multiplies single-cycle; divides always stay iterative.
module alu_control_mdu #(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              rst,
    alu_control_mdu_if.slave io_ex
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo, r_b, r_result;
    logic [2:0]        r_f3;
    logic              r_neg_q, r_neg_r;

    logic              w_md_req, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic              w_div_zero, w_ovf, w_special, w_fast;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special_val, w_fast_val;
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_step_hi, w_step_lo, w_quo, w_rem, w_iter_val;
    logic [2*XLEN-1:0] w_prod;
    logic [3:0]        w_alu_ctl;

    assign w_md_req   = io_ex.valid_in & ~io_ex.flush & (io_ex.alu_op == 3'b000) &
                        (io_ex.funct7 == 7'b0000001);
    assign w_a_signed = (io_ex.funct3 == 3'b001) | (io_ex.funct3 == 3'b010) |
                        (io_ex.funct3 == 3'b100) | (io_ex.funct3 == 3'b110);
    assign w_b_signed = (io_ex.funct3 == 3'b001) | (io_ex.funct3 == 3'b100) |
                        (io_ex.funct3 == 3'b110);
    assign w_sign_a   = w_a_signed & io_ex.op_a[XLEN-1];
    assign w_sign_b   = w_b_signed & io_ex.op_b[XLEN-1];
    assign w_abs_a    = w_sign_a ? -io_ex.op_a : io_ex.op_a;
    assign w_abs_b    = w_sign_b ? -io_ex.op_b : io_ex.op_b;

    // Divide corner cases bypass the iteration entirely
    assign w_div_zero = io_ex.funct3[2] & (io_ex.op_b == '0);
    assign w_ovf      = io_ex.funct3[2] & ~io_ex.funct3[0] &
                        (io_ex.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (io_ex.op_b == '1);
    assign w_special  = w_div_zero | w_ovf;
    always_comb begin
        w_special_val = '1;
        if (w_div_zero)  w_special_val = io_ex.funct3[1] ? io_ex.op_a : '1;
        else if (w_ovf)  w_special_val = io_ex.funct3[1] ? '0 : io_ex.op_a;
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod_fast;
    assign w_prod_fast = {{XLEN{w_sign_a}}, io_ex.op_a} * {{XLEN{w_sign_b}}, io_ex.op_b};
    assign w_fast      = ~io_ex.funct3[2];
    assign w_fast_val  = (io_ex.funct3 == 3'b000) ? w_prod_fast[XLEN-1:0]
                                                  : w_prod_fast[2*XLEN-1:XLEN];
`else
    assign w_fast      = 1'b0;
    assign w_fast_val  = '0;
`endif

    // One shift-add step {hi,lo} (mul) or one restoring-subtract step (div)
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = ~w_diff[XLEN];

    always_comb begin
        if (r_f3[2]) begin
            w_step_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
    assign w_quo  = r_neg_q ? -w_step_lo : w_step_lo;
    assign w_rem  = r_neg_r ? -w_step_hi : w_step_hi;

    always_comb begin
        w_iter_val = w_prod[2*XLEN-1:XLEN];
        case (r_f3)
            3'b000:         w_iter_val = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_iter_val = w_quo;
            3'b110, 3'b111: w_iter_val = w_rem;
            default:        w_iter_val = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_md_req) w_state_next = (w_special | w_fast) ? StDone : StBusy;
            StBusy: begin
                if (io_ex.flush)                     w_state_next = StIdle;
                else if (r_cnt == CNT_W'(1))         w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_f3     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (r_state == StIdle && w_md_req) begin
            r_cnt   <= CNT_W'(XLEN);
            r_hi    <= '0;
            r_lo    <= w_abs_a;
            r_b     <= w_abs_b;
            r_f3    <= io_ex.funct3;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            if (w_special)   r_result <= w_special_val;
            else if (w_fast) r_result <= w_fast_val;
        end else if (r_state == StBusy && !io_ex.flush) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            if (r_cnt == CNT_W'(1)) r_result <= w_iter_val;
        end
    end

    always_comb begin
        w_alu_ctl = 4'b0000;
        case (io_ex.alu_op)
            3'b000: if (io_ex.funct7 != 7'b0000001)
                        w_alu_ctl = {io_ex.funct7[5] & ((io_ex.funct3 == 3'b000) |
                                     (io_ex.funct3 == 3'b101)), io_ex.funct3};
            3'b001: if (io_ex.funct3 != 3'b000)
                        w_alu_ctl = {io_ex.funct7[5] & (io_ex.funct3 == 3'b101), io_ex.funct3};
            3'b011:  w_alu_ctl = 4'b1000;
            default: w_alu_ctl = 4'b0000;
        endcase
    end

    always_comb begin
        io_ex.alu_control_out = w_alu_ctl;
        io_ex.md_sel          = w_md_req;
        io_ex.md_done         = (r_state == StDone);
        io_ex.md_result       = r_result;
        io_ex.stall           = w_md_req & (r_state != StDone) & ~rst;
    end
endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: decode table, directed M-ops, flush/reset, random M-ops.
module tb_alu_control_mdu;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    alu_control_mdu_if #(.XLEN(XLEN)) ex_if ();
    alu_control_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .io_ex(ex_if.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] r_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'b1000 : 4'b0000;  // SUB / ADD
            3'd1: return 4'b0001;
            3'd2: return 4'b0010;
            3'd3: return 4'b0011;
            3'd4: return 4'b0100;
            3'd5: return alt ? 4'b1101 : 4'b0101;  // SRA / SRL
            3'd6: return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        case (op)
            3'd0: return (f7 == 7'b0000001) ? 4'b0000 : r_map(f3, f7[5]);
            3'd1: return (f3 == 3'd0) ? 4'b0000 : r_map(f3, f7[5]);
            3'd3: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int ia, ib;
        logic ovf;
        sa = {{32{a[31]}}, a}; ua = {32'b0, a};
        sb = {{32{b[31]}}, b}; ub = {32'b0, b};
        ia = a; ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : -32'($urandom_range(1, 40));
            2: case ($urandom_range(0, 3))
                   0: return 32'h0;
                   1: return 32'hFFFF_FFFF;
                   2: return 32'h8000_0000;
                   default: return 32'h1;
               endcase
            default: return {1'b0, 31'($urandom)};
        endcase
    endfunction

    // Starts in the low clock phase; leaves one cycle after md_done with valid_in dropped.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int lat;
        bit stall_ok;
        logic [31:0] exp;
        exp = ref_md(f3, a, b);
        ex_if.valid_in = 1'b1; ex_if.flush = 1'b0; ex_if.alu_op = 3'b000;
        ex_if.funct3 = f3; ex_if.funct7 = 7'b0000001; ex_if.op_a = a; ex_if.op_b = b;
        #1;
        check({tag, " stall@N"}, 32'(ex_if.stall), 32'd1);
        check({tag, " md_sel"}, 32'(ex_if.md_sel), 32'd1);
        check({tag, " aluctl"}, 32'(ex_if.alu_control_out), 32'd0);
        lat = 0;
        stall_ok = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (ex_if.md_done) break;
            if (!ex_if.stall) stall_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(ref_lat(f3, a, b)));
        check({tag, " done"}, 32'(ex_if.md_done), 32'd1);
        check({tag, " stall held"}, 32'(stall_ok), 32'd1);
        check({tag, " result"}, ex_if.md_result, exp);
        check({tag, " stall@done"}, 32'(ex_if.stall), 32'd0);
        last_result = exp;
        @(negedge clk);
        ex_if.valid_in = 1'b0;
        #1;
        check({tag, " done pulse"}, 32'(ex_if.md_done), 32'd0);
    endtask

    initial begin
        int idle_done;
        logic [2:0] op, f3;
        logic [6:0] f7;

        rst = 1'b1;
        ex_if.valid_in = 1'b1; ex_if.flush = 1'b0; ex_if.alu_op = 3'b000;
        ex_if.funct3 = 3'b000; ex_if.funct7 = 7'b0000001; ex_if.op_a = 32'd5; ex_if.op_b = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        check("reset stall", 32'(ex_if.stall), 32'd0);
        check("reset done", 32'(ex_if.md_done), 32'd0);
        check("reset result", ex_if.md_result, 32'd0);
        ex_if.valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ALU decode, directed then random (valid_in low so no M-op starts)
        ex_if.alu_op = 3'b000; ex_if.funct3 = 3'b101; ex_if.funct7 = 7'b0100000; #1;
        check("dec SRA", 32'(ex_if.alu_control_out), 32'(4'b1101));
        ex_if.alu_op = 3'b001; ex_if.funct3 = 3'b000; #1;
        check("dec ADDI f7", 32'(ex_if.alu_control_out), 32'(4'b0000));
        ex_if.alu_op = 3'b110; #1;
        check("dec undef", 32'(ex_if.alu_control_out), 32'(4'b0000));
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); f3 = 3'($urandom);
            f7 = $urandom_range(0, 3) == 0 ? 7'b0000001 : {1'b0, 1'($urandom), 5'b0};
            ex_if.alu_op = op; ex_if.funct3 = f3; ex_if.funct7 = f7; #1;
            check("dec rand", 32'(ex_if.alu_control_out), 32'(ref_alu(op, f3, f7)));
        end
        @(negedge clk);

        run_md(3'd0, 32'd7, -32'd3, "MUL 7*-3");
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
        run_md(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH");
        run_md(3'd4, -32'd7, 32'd2, "DIV -7/2");
        run_md(3'd6, -32'd7, 32'd2, "REM -7/2");
        run_md(3'd5, 32'd100, 32'd0, "DIVU /0");
        run_md(3'd7, 32'd100, 32'd0, "REMU /0");
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
        run_md(3'd0, 32'd7, -32'd3, "b2b MUL");
        run_md(3'd4, 32'd1000, -32'd7, "b2b DIV");

        // Flush mid-divide: no md_done, result register untouched
        ex_if.valid_in = 1'b1; ex_if.alu_op = 3'b000; ex_if.funct7 = 7'b0000001;
        ex_if.funct3 = 3'd4; ex_if.op_a = -32'd7; ex_if.op_b = 32'd2;
        repeat (10) @(negedge clk);
        ex_if.flush = 1'b1; #1;
        check("flush stall", 32'(ex_if.stall), 32'd0);
        @(negedge clk);
        ex_if.flush = 1'b0; ex_if.valid_in = 1'b0;
        idle_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ex_if.md_done) idle_done++;
        end
        check("flush no done", 32'(idle_done), 32'd0);
        check("flush result kept", ex_if.md_result, last_result);
        run_md(3'd5, 32'd12345, 32'd17, "after flush");

        // Reset mid-multiply
        ex_if.valid_in = 1'b1; ex_if.funct3 = 3'd0; ex_if.funct7 = 7'b0000001;
        ex_if.op_a = 32'd9; ex_if.op_b = 32'd9;
        repeat (5) @(negedge clk);
        rst = 1'b1; #1;
        check("midrst stall", 32'(ex_if.stall), 32'd0);
        check("midrst done", 32'(ex_if.md_done), 32'd0);
        check("midrst result", ex_if.md_result, 32'd0);
        @(negedge clk);
        ex_if.valid_in = 1'b0; rst = 1'b0;
        idle_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ex_if.md_done) idle_done++;
        end
        check("midrst no done", 32'(idle_done), 32'd0);
        run_md(3'd1, -32'd5, 32'd3, "after rst");

        for (int i = 0; i < 40; i++) begin
            run_md(3'($urandom), pick(), pick(), "rand");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
